// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter plus the IF/ID pipeline register.
// Optional halt-on-opcode support is compiled in when IF_HALT_EN is defined.
module if_stage #(
    parameter logic [31:0] PC_RESET   = 32'd0,
    parameter logic [5:0]  HLT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid
`ifdef IF_HALT_EN
    ,
    output logic        halted
`endif
);

    logic [31:0] pc_q, pc_d, pc_inc;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

`ifdef IF_HALT_EN
    logic        halted_q, halted_d;
    logic        is_hlt;

    assign is_hlt = (imem_data[31:26] == HLT_OPCODE);
    assign halted = halted_q;
`endif

    assign pc_inc      = pc_q + 32'd1;
    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_npc   = npc_q;
    assign if_id_valid = valid_q;

    // Branch outranks stall so a redirect is never lost behind a hazard hold.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
`ifdef IF_HALT_EN
        halted_d = halted_q;
`endif
        if (branch_taken) begin
            pc_d    = branch_target;
            instr_d = 32'd0;
            npc_d   = 32'd0;
            valid_d = 1'b0;
`ifdef IF_HALT_EN
            halted_d = 1'b0;
`endif
        end else if (!stall) begin
`ifdef IF_HALT_EN
            if (halted_q) begin
                // Parked after HLT: PC frozen, IF/ID drained to a bubble.
                instr_d = 32'd0;
                valid_d = 1'b0;
            end else begin
                instr_d  = imem_data;
                npc_d    = pc_inc;
                valid_d  = 1'b1;
                pc_d     = pc_inc;
                halted_d = is_hlt;
            end
`else
            instr_d = imem_data;
            npc_d   = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
`ifdef IF_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
`ifdef IF_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan scenarios, then random stall/branch/reset traffic,
// all checked by a queue-based scoreboard fed from a spec-level model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] PcReset = 32'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
`ifdef IF_HALT_EN
    logic        halted;
`endif
    logic        halt_mode = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic        hlt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_npc = 32'd0;
    logic        m_valid = 1'b0, m_halted = 1'b0;

    if_stage #(
        .PC_RESET  (PcReset),
        .HLT_OPCODE(6'b111111)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_id_instr  (if_id_instr),
        .if_id_npc    (if_id_npc),
        .if_id_valid  (if_id_valid)
`ifdef IF_HALT_EN
        ,
        .halted       (halted)
`endif
    );

    always #5 clk = ~clk;

    // Sparse memory image; hashed words keep bit 31 clear so they never decode as HLT.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic hm);
        if (hm && a == 32'd3) return 32'hFC00_0000;
        case (a)
            32'd0:   return 32'h11;
            32'd1:   return 32'h22;
            32'd2:   return 32'h33;
            32'd3:   return 32'h44;
            default: return ((a * 32'h9E37_79B1) ^ 32'h1357_2468) & 32'h7FFF_FFFF;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr, halt_mode);

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and push the post-edge expectation.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        exp_t e;
        @(negedge clk);
        rst = r;
        stall = s;
        branch_taken = b;
        branch_target = t;
        if (r) begin
            m_pc = PcReset; m_instr = 0; m_npc = 0; m_valid = 0; m_halted = 0;
        end else if (b) begin
            m_pc = t; m_instr = 0; m_npc = 0; m_valid = 0; m_halted = 0;
        end else if (s) begin
            // hold everything
        end else if (m_halted) begin
            m_instr = 0; m_valid = 0;
        end else begin
            m_instr = mem_word(m_pc, halt_mode);
            m_npc   = m_pc + 32'd1;
            m_valid = 1'b1;
`ifdef IF_HALT_EN
            m_halted = (m_instr[31:26] == 6'b111111);
`endif
            m_pc    = m_pc + 32'd1;
        end
        e.pc = m_pc; e.instr = m_instr; e.npc = m_npc; e.valid = m_valid; e.hlt = m_halted;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a fresh IF/ID state, checked against the queue.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("sb_imem_addr", imem_addr, mon_e.pc);
            cmp("sb_instr", if_id_instr, mon_e.instr);
            cmp("sb_npc", if_id_npc, mon_e.npc);
            cmp("sb_valid", {31'd0, if_id_valid}, {31'd0, mon_e.valid});
`ifdef IF_HALT_EN
            cmp("sb_halted", {31'd0, halted}, {31'd0, mon_e.hlt});
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hold_instr, hold_npc;
        logic        r, s, b;
        logic [31:0] t;

        // Reset and stream
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        settle();
        cmp("rst_valid", {31'd0, if_id_valid}, 32'd0);
        cmp("rst_addr", imem_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            settle();
            cmp("stream_instr", if_id_instr, 32'h11 * (i + 1));
            cmp("stream_npc", if_id_npc, i + 1);
        end

        // Stall at pc=5
        step(0, 0, 0, 0);
        settle();
        hold_instr = if_id_instr;
        hold_npc = if_id_npc;
        cmp("pre_stall_npc", hold_npc, 32'd5);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            settle();
            cmp("stall_addr", imem_addr, 32'd5);
            cmp("stall_instr", if_id_instr, mem_word(32'd4, 1'b0));
            cmp("stall_npc", if_id_npc, 32'd5);
        end
        step(0, 0, 0, 0);
        settle();
        cmp("unstall_instr", if_id_instr, mem_word(32'd5, 1'b0));
        cmp("unstall_npc", if_id_npc, 32'd6);
        step(0, 0, 0, 0);
        settle();
        cmp("pre_branch_addr", imem_addr, 32'd7);

        // Branch, then branch together with stall
        for (int k = 0; k < 2; k++) begin
            step(0, k[0], 1, 32'h40);
            settle();
            cmp("br_valid", {31'd0, if_id_valid}, 32'd0);
            cmp("br_instr", if_id_instr, 32'd0);
            cmp("br_addr", imem_addr, 32'h40);
            step(0, 0, 0, 0);
            settle();
            cmp("br_tgt_instr", if_id_instr, mem_word(32'h40, 1'b0));
            cmp("br_tgt_npc", if_id_npc, 32'h41);
        end

        // Wrap and mid-run reset
        step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        settle();
        cmp("wrap_npc", if_id_npc, 32'd0);
        cmp("wrap_addr", imem_addr, 32'd0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        settle();
        cmp("midrst_addr", imem_addr, PcReset);
        cmp("midrst_valid", {31'd0, if_id_valid}, 32'd0);

`ifdef IF_HALT_EN
        // Halt at address 3
        halt_mode = 1'b1;
        step(0, 0, 1, 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        settle();
        cmp("hlt_instr", if_id_instr, 32'hFC00_0000);
        cmp("hlt_valid", {31'd0, if_id_valid}, 32'd1);
        cmp("hlt_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0);
            settle();
            cmp("hlt_bubble_valid", {31'd0, if_id_valid}, 32'd0);
            cmp("hlt_bubble_addr", imem_addr, 32'd4);
        end
        step(0, 0, 1, 32'h10);
        settle();
        cmp("hlt_clear", {31'd0, halted}, 32'd0);
        step(0, 0, 0, 0);
        settle();
        cmp("hlt_resume_instr", if_id_instr, mem_word(32'h10, 1'b1));
        cmp("hlt_resume_npc", if_id_npc, 32'h11);
        halt_mode = 1'b0;
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = $urandom_range(0, 1) ? (32'hFFFF_FFFC + $urandom_range(0, 3)) : $urandom;
            step(r, s, b, t);
        end
        step(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        cmp("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
